// File: rtl/uart_input_manager.sv
// uart_input_manager: 8N1 UART receiver plus a hex line parser.
// Each line of ASCII hex digits that ends in CR or LF becomes a right-aligned
// binary value with a one-cycle ready_out strobe. A malformed line reports an
// error code instead of a value.
module uart_input_manager #(
  parameter int RESULT_SIZE = 4,
  parameter int CLOCK_RATE  = 100_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RsRx,
  output logic [RESULT_SIZE*4-1:0] data_out,
  output logic [1:0]               error_out,
  output logic                     ready_out
);

  localparam int BIT_TICKS  = CLOCK_RATE / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = $clog2(BIT_TICKS);
  localparam int DW         = RESULT_SIZE * 4;
  localparam int DC_W       = $clog2(RESULT_SIZE + 1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CHAR  = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // ASCII hex digit classifier: '0'-'9', 'A'-'F' or 'a'-'f'.
  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Letters have bit 6 set and their low nibble is 1..6, so adding 9 gives A..F.
  function automatic logic [3:0] hex_nibble(input logic [7:0] b);
    return b[6] ? (b[3:0] + 4'd9) : b[3:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  logic             sync1_q, sync2_q, prev_q;
  rx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  // Two-flop synchroniser for the async pin, plus a previous-sample register for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= RsRx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // RX FSM: start-bit qualification at mid-bit, then 8 data bits and the stop bit, each one bit period apart.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (prev_q && !sync2_q) begin
            cnt_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_W'(HALF_TICKS - 1)) begin
            cnt_q <= '0;
            if (!sync2_q) begin
              bit_idx_q <= 3'd0;
              state_q   <= ST_DATA;
            end else begin
              // The line went back high before mid-bit, so treat it as a glitch.
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_W'(BIT_TICKS - 1)) begin
            cnt_q     <= '0;
            shift_q   <= {sync2_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_W'(BIT_TICKS - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            if (sync2_q) begin
              rx_byte_q    <= shift_q;
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Line parser
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   acc_q, acc_d;
  logic [DC_W-1:0] digit_cnt_q, digit_cnt_d;
  logic [1:0]      err_q, err_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      error_q, error_d;
  logic            ready_q, ready_d;

  // Parser next state: accumulate digits and latch the first error; a terminator emits the line.
  always_comb begin
    acc_d       = acc_q;
    digit_cnt_d = digit_cnt_q;
    err_d       = err_q;
    data_d      = data_q;
    error_d     = error_q;
    ready_d     = 1'b0;
    if (frame_err_q) begin
      if (err_q == ERR_NONE) begin
        err_d = ERR_FRAME;
      end else begin
        err_d = err_q;
      end
    end else if (byte_valid_q) begin
      if (is_hex(rx_byte_q)) begin
        if (digit_cnt_q < DC_W'(RESULT_SIZE)) begin
          acc_d       = {acc_q[DW-5:0], hex_nibble(rx_byte_q)};
          digit_cnt_d = digit_cnt_q + DC_W'(1);
        end else if (err_q == ERR_NONE) begin
          err_d = ERR_OVF;
        end else begin
          err_d = err_q;
        end
      end else if ((rx_byte_q == 8'h0D) || (rx_byte_q == 8'h0A)) begin
        if ((digit_cnt_q == DC_W'(0)) && (err_q == ERR_NONE)) begin
          // A blank line, or the second half of a CRLF pair, produces no output.
          ready_d = 1'b0;
        end else begin
          if (err_q == ERR_NONE) begin
            data_d  = acc_q;
            error_d = ERR_NONE;
          end else begin
            data_d  = '0;
            error_d = err_q;
          end
          ready_d     = 1'b1;
          acc_d       = '0;
          digit_cnt_d = '0;
          err_d       = ERR_NONE;
        end
      end else if (err_q == ERR_NONE) begin
        err_d = ERR_CHAR;
      end else begin
        err_d = err_q;
      end
    end else begin
      ready_d = 1'b0;
    end
  end

  // Parser state and the registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q       <= '0;
      digit_cnt_q <= '0;
      err_q       <= ERR_NONE;
      data_q      <= '0;
      error_q     <= ERR_NONE;
      ready_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      digit_cnt_q <= digit_cnt_d;
      err_q       <= err_d;
      data_q      <= data_d;
      error_q     <= error_d;
      ready_q     <= ready_d;
    end
  end

  assign data_out  = data_q;
  assign error_out = error_q;
  assign ready_out = ready_q;

endmodule

// File: tb/tb_uart_input_manager.sv
// Testbench for uart_input_manager: it sends directed line vectors from a
// table, then runs hand-written sequences for framing, glitch and reset cases.
module tb_uart_input_manager;

  localparam int BIT_TICKS = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        RsRx;
  logic [15:0] data_out;
  logic [1:0]  error_out;
  logic        ready_out;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  int hold_viol = 0;
  logic        in_reset = 1'b1;
  logic [15:0] last_data;
  logic [1:0]  last_err;

  uart_input_manager #(
    .RESULT_SIZE(4),
    .CLOCK_RATE (1_000_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RsRx     (RsRx),
    .data_out (data_out),
    .error_out(error_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  // Count cycles with ready_out high, and watch that the outputs change only with ready_out.
  always @(negedge clk) begin
    if (ready_out) pulse_cnt <= pulse_cnt + 1;
    if (!in_reset && !ready_out && ((data_out !== last_data) || (error_out !== last_err)))
      hold_viol <= hold_viol + 1;
    last_data <= data_out;
    last_err  <= error_out;
  end

  typedef struct {
    string       name;
    logic [63:0] str;
    int          n;
    logic [15:0] exp_data;
    logic [1:0]  exp_err;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RsRx = 1'b0;
    wait_cycles(BIT_TICKS);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      wait_cycles(BIT_TICKS);
    end
    RsRx = stop_bit;
    wait_cycles(BIT_TICKS);
  endtask

  task automatic send_str(input logic [63:0] s, input int n);
    for (int i = 0; i < n; i++) send_byte(s[8*(n-1-i) +: 8], 1'b1);
  endtask

  initial begin
    int p0;
    vecs[0] = '{"line_1A",     64'("1A\r"),      3, 16'h001A, 2'd0, 1};
    vecs[1] = '{"line_ff3C",   64'("ff3C\r\n"),  6, 16'hFF3C, 2'd0, 1};
    vecs[2] = '{"bad_char",    64'("12G4\r"),    5, 16'h0000, 2'd1, 1};
    vecs[3] = '{"after_err",   64'("7\n"),       2, 16'h0007, 2'd0, 1};
    vecs[4] = '{"overflow",    64'("12345\r"),   6, 16'h0000, 2'd2, 1};
    vecs[5] = '{"first_wins",  64'("Z12345\r"),  7, 16'h0000, 2'd1, 1};

    RsRx  = 1'b1;
    reset = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);
    in_reset = 1'b0;
    check("reset_data",  32'(data_out),  32'h0);
    check("reset_err",   32'(error_out), 32'h0);
    check("reset_ready", 32'(ready_out), 32'h0);

    // Table-driven line vectors.
    for (int v = 0; v < 6; v++) begin
      p0 = pulse_cnt;
      send_str(vecs[v].str, vecs[v].n);
      wait_cycles(20);
      check({vecs[v].name, "_pulses"}, 32'(pulse_cnt - p0), 32'(vecs[v].exp_pulses));
      check({vecs[v].name, "_data"},   32'(data_out),       32'(vecs[v].exp_data));
      check({vecs[v].name, "_err"},    32'(error_out),      32'(vecs[v].exp_err));
    end

    // Framing error: '5', a frame whose stop bit is 0, then CR.
    p0 = pulse_cnt;
    send_str(64'("5"), 1);
    send_byte(8'h41, 1'b0);
    RsRx = 1'b1;
    wait_cycles(5);
    send_str(64'("\r"), 1);
    wait_cycles(20);
    check("frame_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("frame_data",   32'(data_out),       32'h0);
    check("frame_err",    32'(error_out),      32'h3);

    // Glitch: a 2-cycle low on the idle line; a following CR has to stay silent.
    p0 = pulse_cnt;
    RsRx = 1'b0;
    wait_cycles(2);
    RsRx = 1'b1;
    wait_cycles(200);
    send_str(64'("\r"), 1);
    wait_cycles(20);
    check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("glitch_err",    32'(error_out),      32'h3);

    // Reset partway through the data bits of '9' after "12".
    p0 = pulse_cnt;
    send_str(64'("12"), 2);
    RsRx = 1'b0;
    wait_cycles(BIT_TICKS);
    RsRx = 1'b1; wait_cycles(BIT_TICKS);
    RsRx = 1'b0; wait_cycles(BIT_TICKS);
    wait_cycles(5);
    in_reset = 1'b1;
    reset = 1'b0;
    wait_cycles(1);
    reset = 1'b1;
    RsRx  = 1'b1;
    wait_cycles(30);
    in_reset = 1'b0;
    wait_cycles(100);
    check("rst_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("rst_data",   32'(data_out),       32'h0);
    check("rst_err",    32'(error_out),      32'h0);
    send_str(64'("3\r"), 2);
    wait_cycles(20);
    check("post_rst_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("post_rst_data",   32'(data_out),       32'h0003);
    check("post_rst_err",    32'(error_out),      32'h0);

    check("output_hold", 32'(hold_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_input_manager.md
# uart_input_manager

Receive side of the board's UART console. Deserialises 8N1 frames from the `RsRx` pin, parses lines of ASCII hex digits terminated by CR or LF, and presents each completed line as a right-aligned binary value with a one-cycle `ready_out` strobe. Malformed lines are reported through an error code instead. The block feeds operands from the host PC into the compute core, the reverse of the result/error console output path.

## Interface
- `RESULT_SIZE`, 4: maximum hex digits per line; `data_out` is `RESULT_SIZE*4` bits.
- `CLOCK_RATE`, 100_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, 9600: line rate in baud.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `RsRx` in 1: asynchronous serial input, idle high.
- `data_out` out `RESULT_SIZE*4`: parsed value of the last good line; 0 after an error line.
- `error_out` out 2: 0 = none, 1 = invalid character, 2 = digit overflow, 3 = framing error.
- `ready_out` out 1: one-cycle pulse when `data_out`/`error_out` are updated.

## Operation
- Constants:
  - `BIT_TICKS = CLOCK_RATE/BAUD_RATE`, using integer division.
  - `HALF_TICKS = BIT_TICKS/2`.
  - The tick counter is `$clog2(BIT_TICKS)` bits wide.
- Input path: `RsRx` passes through a 2-FF synchroniser. A third register holds the previous synchronised sample for edge detection.
- RX FSM:
  - IDLE: on a falling edge (prev=1, cur=0), clear the counter and go to START.
  - START: at count `HALF_TICKS-1`, if the line is still 0, clear the counter and bit index and go to DATA. Otherwise return to IDLE (glitch, no output).
  - DATA: at count `BIT_TICKS-1`, sample the bit into the byte shift register LSB-first and clear the counter. After the 8th bit, go to STOP.
  - STOP: at count `BIT_TICKS-1`, sample the bit:
    - 1: pulse internal `byte_valid` with the byte.
    - 0: pulse `frame_err` and discard the byte.
    - Either way, go to IDLE.
  - IDLE needs a new falling edge to start, so a held-low break produces exactly one framing error.
- Parser registers:
  - `acc` (`RESULT_SIZE*4` bits).
  - `digit_cnt` (`$clog2(RESULT_SIZE+1)` bits).
  - `err` (2 bits); the first error in a line wins and later errors do not overwrite it.
- Parser actions on `byte_valid`:
  - `'0'-'9'`, `'A'-'F'`, `'a'-'f'`:
    - If `digit_cnt < RESULT_SIZE`: `acc <= {acc[RESULT_SIZE*4-5:0], nibble}` and `digit_cnt++`.
    - Otherwise: set `err=2` if `err==0`.
  - CR (8'h0D) or LF (8'h0A):
    - If `digit_cnt==0` and `err==0`: ignore, so CRLF pairs and blank lines are silent.
    - Otherwise emit:
      - `err==0`: `data_out<=acc`, `error_out<=0`.
      - Else: `data_out<=0`, `error_out<=err`.
      - `ready_out<=1`.
      - Clear `acc`, `digit_cnt` and `err`.
  - Any other byte: set `err=1` if `err==0`.
- On `frame_err`: set `err=3` if `err==0`.
- Lines shorter than `RESULT_SIZE` are zero-extended, because `acc` starts each line at 0.

## Timing
- Reset (`reset==0` at a clock edge):
  - RX FSM goes to IDLE.
  - Synchroniser and edge registers load 1.
  - Counters, `acc`, `err`, `data_out`, `error_out` and `ready_out` load 0.
  - A partial frame or line in progress is discarded with no pulse.
- A data bit is sampled `BIT_TICKS` after the start-bit midpoint, ±1 cycle of quantisation.
- `byte_valid` is asserted in the cycle after the stop-bit sample edge.
- `ready_out` is asserted in the cycle after the terminator's `byte_valid`. It is high for exactly one cycle.
- `data_out` and `error_out` change only in the same cycle `ready_out` is asserted, and hold otherwise.
- Back-to-back frames (next start bit right after the stop bit) must be received without loss.
- The block has no input backpressure. The consumer must accept a `ready_out` pulse on the cycle it occurs.

## Test plan
- Bench configuration: `CLOCK_RATE=1_000_000`, `BAUD_RATE=100_000` (`BIT_TICKS=10`), `RESULT_SIZE=4`, unless stated.
- Send "1A",CR -> exactly one `ready_out` pulse; `data_out=16'h001A`, `error_out=0`.
- Send "ff3C",CR,LF back-to-back -> one pulse; `data_out=16'hFF3C`, `error_out=0`; no pulse for the LF.
- Send "12G4",CR -> one pulse; `error_out=1`, `data_out=0`. Next send "7",LF -> `data_out=16'h0007`, `error_out=0`.
- Send "12345",CR -> `error_out=2`. Then "Z12345",CR -> `error_out=1` (first error wins).
- Send "5", then a frame with stop bit 0, then CR -> `error_out=3`, `data_out=0`. Also send a 2-cycle low glitch on idle `RsRx` -> no byte received.
- Assert `reset` low for 1 cycle mid-way through the data bits of '9' after "12", then send "3",CR -> `data_out=16'h0003`, `error_out=0`; no pulse during or after reset.
